// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer read scheduler.
package accel_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Register owned by each requester; entry 0 is the rightmost element.
  localparam logic [MAX_REQ-1:0][ADDR_W-1:0] REG_ADDR = {
    6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h36, 6'h34, 6'h32
  };

  function automatic logic [ADDR_W-1:0] reg_addr_of(input logic [2:0] id);
    return REG_ADDR[id];
  endfunction

endpackage

// File: rtl/accel_read_scheduler_if.sv
// Requester-side and SPI-engine-side signals of the read scheduler.
interface accel_read_scheduler_if #(
  parameter int unsigned N_REQ = 4
) ();
  import accel_pkg::*;

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  req;
  logic              spi_ready;
  logic              spi_start;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_rw;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;
  logic              res_valid;
  logic [ID_W-1:0]   res_id;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              req_dropped;

  modport master (
    input  req, spi_ready, spi_done, spi_rdata,
    output spi_start, spi_addr, spi_rw, res_valid, res_id, res_data, res_err, req_dropped
  );

  modport slave (
    output req, spi_ready, spi_done, spi_rdata,
    input  spi_start, spi_addr, spi_rw, res_valid, res_id, res_data, res_err, req_dropped
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set pend bit after last, wrapping.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend_i,
  input  logic [ID_W-1:0]  last_i,
  output logic             any_o,
  output logic [ID_W-1:0]  winner_o
);

  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!any_o && pend_i[ID_W'((32'(last_i) + k) % N_REQ)]) begin
        any_o    = 1'b1;
        winner_o = ID_W'((32'(last_i) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/accel_read_scheduler.sv
// Shares one SPI engine among N_REQ one-shot read requesters, round-robin,
// with a per-transfer timeout and ID-tagged results.
module accel_read_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  accel_read_scheduler_if.master bus_if
);
  import accel_pkg::*;

  localparam int unsigned ID_W    = $clog2(N_REQ);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              drop_q, drop_d;

  logic              any_c;
  logic [ID_W-1:0]   winner_c;
  logic              issue_c;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .pend_i   (pend_q),
    .last_i   (last_q),
    .any_o    (any_c),
    .winner_o (winner_c)
  );

  assign issue_c = (state_q == S_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      g_q         <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    last_d      = last_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    addr_d      = addr_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    drop_d      = drop_q;

    // A new request beats the issue-cycle clear of the same requester.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (bus_if.req[i]) begin
        if (pend_q[i] && !(issue_c && g_q == ID_W'(i))) drop_d = 1'b1;
        pend_d[i] = 1'b1;
      end else if (issue_c && g_q == ID_W'(i)) begin
        pend_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (any_c) begin
          g_d     = winner_c;
          state_d = S_ARB;
        end
      end
      // Start strobe and address are registered on entry to ISSUE.
      S_ARB: begin
        if (bus_if.spi_ready) begin
          start_d = 1'b1;
          addr_d  = reg_addr_of(3'(g_q));
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        last_d  = g_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_if.spi_done) begin
          res_valid_d = 1'b1;
          res_id_d    = g_q;
          res_data_d  = bus_if.spi_rdata;
          res_err_d   = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          res_valid_d = 1'b1;
          res_id_d    = g_q;
          res_data_d  = '0;
          res_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.spi_start   = start_q;
  assign bus_if.spi_addr    = addr_q;
  assign bus_if.spi_rw      = 1'b1;
  assign bus_if.res_valid   = res_valid_q;
  assign bus_if.res_id      = res_id_q;
  assign bus_if.res_data    = res_data_q;
  assign bus_if.res_err     = res_err_q;
  assign bus_if.req_dropped = drop_q;

endmodule

// File: doc/accel_read_scheduler.md
# accel_read_scheduler

Round-robin scheduler that shares the single SPI transaction engine among up to N one-shot read requesters (button pulse generators, sample timers). Each requester owns one accelerometer register. The block latches request pulses, grants the SPI engine to one requester at a time, supervises the transfer with a timeout and returns the read byte tagged with the requester ID. It sits between the pulse generators and the SPI master.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8
- `TIMEOUT`, 255: max cycles to wait for `spi_done` after `spi_start`, range ≥1
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  one-cycle request pulses, bit i = requester i
- `spi_ready`  in  1  SPI engine idle and able to accept a start
- `spi_start`  out  1  one-cycle start strobe to the SPI engine
- `spi_addr`  out  6  register address, held stable from `spi_start` until `spi_done` or timeout
- `spi_rw`  out  1  constant 1 (read)
- `spi_done`  in  1  one-cycle transfer-complete strobe
- `spi_rdata`  in  8  read byte, valid with `spi_done`
- `res_valid`  out  1  one-cycle result strobe
- `res_id`  out  clog2(N_REQ)  requester that owns the result
- `res_data`  out  8  captured byte, 0x00 on error
- `res_err`  out  1  1 = transfer timed out, qualified by `res_valid`
- `req_dropped`  out  1  sticky; set when a request arrives while that requester is already pending; cleared only by reset

## Operation
- Pending vector `pend[N_REQ]`: `req[i]` sets `pend[i]`. `pend[i]` clears on the cycle requester i is issued. If `req[i]` arrives in that same cycle, the set wins and `pend[i]` stays 1. A `req[i]` while `pend[i]=1` and not being cleared sets `req_dropped`.
- Round-robin pointer `last`, reset to N_REQ-1. The search starts at `last+1` and wraps modulo N_REQ; the first set `pend` bit wins. `last` updates to the winner at issue.
- FSM states:
  - IDLE: if any `pend`, latch winner `g`, go ARB.
  - ARB: wait for `spi_ready=1`, then go ISSUE.
  - ISSUE: `spi_start=1` for exactly this cycle, `spi_addr=REG_ADDR[g]`, clear `pend[g]`, zero the timeout counter, go WAIT.
  - WAIT: on `spi_done`, capture `spi_rdata` with err=0 and go DONE. If the counter reaches TIMEOUT first, set data=0x00 and err=1 and go DONE. If `spi_done` arrives in the same cycle the counter reaches TIMEOUT, `spi_done` wins.
  - DONE: `res_valid=1` with `res_id=g`, `res_data`, `res_err`, go IDLE.
- `spi_done` outside WAIT is ignored.
- Timeout counter width is clog2(TIMEOUT+1) and saturates; it counts only in WAIT.

## Timing
- Reset values: `spi_start=0`, `spi_addr=0`, `spi_rw=1`, `res_valid=0`, `res_id=0`, `res_data=0`, `res_err=0`, `req_dropped=0`, `pend=0`, state IDLE, `last=N_REQ-1`.
- All outputs are registered.
- Reset asserted mid-transfer drops all pending requests and the in-flight transfer immediately. No `res_valid` is emitted for the aborted transfer.
- `req[i]` at cycle t gives `pend[i]=1` at t+1 and the IDLE decision at t+1. ARB is at t+2. With `spi_ready=1`, `spi_start` is high at t+3.
- `spi_done` at cycle d gives `res_valid` at d+1. IDLE is at d+2, and the earliest next `spi_start` is at d+4.
- A timeout asserts `res_valid` TIMEOUT+2 cycles after `spi_start`.
- `res_*` outputs hold their values until the next `res_valid`.

## Structure
- Package `accel_pkg`:
  - FSM state enum
  - `REG_ADDR` table, indexed by requester: 0→0x32 DATAX0, 1→0x34 DATAY0, 2→0x36 DATAZ0, 3→0x00 DEVID, entries 4..7 → 0x00
  - `ADDR_W=6`, `DATA_W=8`
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `pend` and `last`; outputs are `any` and `winner`.

## Test plan
- Single request: pulse `req[2]`, `spi_ready=1`, then `spi_done` with 0xA5 four cycles after `spi_start` → `spi_start` at t+3 with `spi_addr=0x36`, then `res_valid` with `res_id=2`, `res_data=0xA5`, `res_err=0`.
- Fairness: pulse `req=4'b1111` at once, answer every transfer → issue order 0, 1, 2, 3. Then pulse `req[0]` and `req[3]` → order 0, 3.
- Timeout: `TIMEOUT=8`, pulse `req[1]`, never assert `spi_done` → `res_valid` 10 cycles after `spi_start` with `res_err=1`, `res_data=0x00`. A late `spi_done` is ignored.
- Busy engine: pulse `req[0]` with `spi_ready=0` for 20 cycles → no `spi_start` during that time. `spi_start` is high the cycle after ARB first sees `spi_ready=1`.
- Drop and collision: pulse `req[3]` twice while it is pending → `req_dropped=1`, one transfer only. Pulse `req[g]` in its ISSUE cycle → a second transfer for g follows.
- Async reset: assert `rst_n=0` during WAIT → all outputs return to reset values immediately. After release, no `res_valid` appears for the aborted transfer.
